// File: rtl/apb_reg_bank.sv
// apb_reg_bank
// APB slave exposing NUM_REGS DATA_W-bit control registers with byte-lane
// write strobes, a configurable number of access wait states, per-register
// read-only masking and error signalling for misaligned, out-of-range or
// read-only-write accesses.
//
// Ports
//   pclk      in   clock, all logic on the rising edge
//   preset    in   synchronous active-high reset
//   paddr     in   ADDR_W   byte address
//   psel      in   slave select
//   penable   in   access phase qualifier
//   pwrite    in   1 = write, 0 = read
//   pwdata    in   DATA_W   write data
//   pstrb     in   DATA_W/8 byte-lane write strobes
//   pready    out  transfer complete (registered, one cycle per transfer)
//   pslverr   out  transfer error, valid with pready (registered)
//   prdata    out  DATA_W   read data, zero whenever pready is low (registered)
//   reg_q     out  NUM_REGS*DATA_W register contents, reg i at [i*DATA_W +: DATA_W]
//   wr_pulse  out  NUM_REGS one-cycle pulse on bit i when reg i is written

module apb_reg_bank #(
  parameter int               NUM_REGS    = 8,
  parameter int               DATA_W      = 32,
  parameter int               ADDR_W      = 32,
  parameter int               WAIT_STATES = 1,
  parameter logic [255:0]     RO_MASK     = 256'h80,
  parameter logic [DATA_W-1:0] RESET_VAL  = '0
) (
  input  logic                       pclk,
  input  logic                       preset,
  input  logic [ADDR_W-1:0]          paddr,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [DATA_W-1:0]          pwdata,
  input  logic [DATA_W/8-1:0]        pstrb,
  output logic                       pready,
  output logic                       pslverr,
  output logic [DATA_W-1:0]          prdata,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        wr_pulse
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Latched transfer; setups arriving in ACCESS/RESP never overwrite these.
  logic [3:0]          cnt_reg, cnt_next;
  logic [ADDR_W-1:0]   addr_reg;
  logic                write_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [STRB_W-1:0]   strb_reg;

  logic                pready_reg, pready_next;
  logic                pslverr_reg, pslverr_next;
  logic [DATA_W-1:0]   prdata_reg, prdata_next;
  logic [NUM_REGS-1:0] wr_pulse_reg, wr_pulse_next;

  logic [DATA_W-1:0]   reg_view [NUM_REGS];

  logic                setup;
  logic                do_access;
  logic [IDX_W-1:0]    idx;
  logic                addr_err;
  logic                ro_err;
  logic                xfer_err;

  assign setup     = psel && !penable;
  assign do_access = (state_reg == ACCESS) && psel && (cnt_reg == '0);

  // Decode of the latched address.
  assign idx      = addr_reg[IDX_W+1:2];
  assign addr_err = (addr_reg[1:0] != 2'b00) || ((addr_reg >> (IDX_W + 2)) != '0);
  assign ro_err   = write_reg && RO_MASK[idx];
  assign xfer_err = addr_err || ro_err;

  // State register
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (setup) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_next = IDLE;
        end else if (cnt_reg == '0) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output / datapath next values. Everything defaults to zero so the
  // response outputs drop automatically in the cycle after pready.
  always_comb begin
    pready_next   = 1'b0;
    pslverr_next  = 1'b0;
    prdata_next   = '0;
    wr_pulse_next = '0;
    cnt_next      = cnt_reg;

    if ((state_reg == IDLE) && setup) begin
      cnt_next = 4'(WAIT_STATES);
    end else if ((state_reg == ACCESS) && psel && (cnt_reg != '0)) begin
      cnt_next = cnt_reg - 4'd1;
    end

    if (do_access) begin
      pready_next = 1'b1;
      if (xfer_err) begin
        pslverr_next = 1'b1;
      end else if (write_reg) begin
        wr_pulse_next[idx] = 1'b1;
      end else begin
        prdata_next = reg_view[idx];
      end
    end
  end

  // Datapath and response registers
  always_ff @(posedge pclk) begin
    if (preset) begin
      cnt_reg      <= '0;
      addr_reg     <= '0;
      write_reg    <= 1'b0;
      wdata_reg    <= '0;
      strb_reg     <= '0;
      pready_reg   <= 1'b0;
      pslverr_reg  <= 1'b0;
      prdata_reg   <= '0;
      wr_pulse_reg <= '0;
    end else begin
      cnt_reg      <= cnt_next;
      pready_reg   <= pready_next;
      pslverr_reg  <= pslverr_next;
      prdata_reg   <= prdata_next;
      wr_pulse_reg <= wr_pulse_next;
      if ((state_reg == IDLE) && setup) begin
        addr_reg  <= paddr;
        write_reg <= pwrite;
        wdata_reg <= pwdata;
        strb_reg  <= pstrb;
      end
    end
  end

  // Register storage. The write is committed on the RESP edge (wr_pulse is
  // high in the pready cycle), so reg_q changes one cycle after pready and a
  // reset arriving in RESP still cancels the update.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (RO_MASK[gi]) begin : g_ro
      assign reg_view[gi] = RESET_VAL;
    end else begin : g_rw
      logic [DATA_W-1:0] val_reg;
      always_ff @(posedge pclk) begin
        if (preset) begin
          val_reg <= RESET_VAL;
        end else if ((state_reg == RESP) && wr_pulse_reg[gi]) begin
          for (int k = 0; k < STRB_W; k++) begin
            if (strb_reg[k]) begin
              val_reg[8*k +: 8] <= wdata_reg[8*k +: 8];
            end
          end
        end
      end
      assign reg_view[gi] = val_reg;
    end
    assign reg_q[gi*DATA_W +: DATA_W] = reg_view[gi];
  end

  assign pready   = pready_reg;
  assign pslverr  = pslverr_reg;
  assign prdata   = prdata_reg;
  assign wr_pulse = wr_pulse_reg;

endmodule

// File: tb/tb_apb_reg_bank.sv
module tb_apb_reg_bank;

  localparam logic [7:0] RO = 8'h80;

  logic         pclk = 1'b0;
  logic         preset;
  logic [31:0]  paddr;
  logic         psel, penable, pwrite;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;

  logic         pready, pslverr;
  logic [31:0]  prdata;
  logic [255:0] reg_q;
  logic [7:0]   wr_pulse;

  logic         pready0, pslverr0;
  logic [31:0]  prdata0;
  logic [255:0] reg_q0;
  logic [7:0]   wr_pulse0;

  logic         pready4, pslverr4;
  logic [31:0]  prdata4;
  logic [255:0] reg_q4;
  logic [7:0]   wr_pulse4;

  always #5 pclk = ~pclk;

  apb_reg_bank #(.WAIT_STATES(1)) dut (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pready(pready),
    .pslverr(pslverr), .prdata(prdata), .reg_q(reg_q), .wr_pulse(wr_pulse)
  );

  apb_reg_bank #(.WAIT_STATES(0)) dut_ws0 (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pready(pready0),
    .pslverr(pslverr0), .prdata(prdata0), .reg_q(reg_q0), .wr_pulse(wr_pulse0)
  );

  apb_reg_bank #(.WAIT_STATES(4)) dut_ws4 (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pready(pready4),
    .pslverr(pslverr4), .prdata(prdata4), .reg_q(reg_q4), .wr_pulse(wr_pulse4)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: plain array of register values.
  logic [31:0] model [8];

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wd;
    logic [3:0]  st;
    logic        b2b;
    logic        err;
    logic [31:0] rd;
    logic [7:0]  wp;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[i*32 +: 32] = model[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
  endtask

  // Applies the bank's rules to one transfer and updates the model.
  task automatic model_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                            input logic [3:0] st, output logic err, output logic [31:0] rd,
                            output logic [7:0] wp);
    int ix;
    ix  = int'(addr / 4) % 8;
    err = (addr % 4 != 0) || (addr >= 32) || (wr && RO[ix]);
    rd  = 32'h0;
    wp  = 8'h0;
    if (!err) begin
      if (wr) begin
        wp = 8'h1 << ix;
        for (int k = 0; k < 4; k++)
          if (st[k]) model[ix][8*k +: 8] = wd[8*k +: 8];
      end else begin
        rd = model[ix];
      end
    end
  endtask

  // Drives one full transfer starting in the current cycle (caller is #1
  // after an edge), waits for pready, then samples the following cycle.
  task automatic xfer_check(input string tag, input logic [31:0] addr, input logic wr,
                            input logic [31:0] wd, input logic [3:0] st,
                            input logic exp_err, input logic [31:0] exp_rd,
                            input logic [7:0] exp_wp);
    int          lat;
    logic        got;
    logic        err;
    logic [31:0] rd;
    logic [7:0]  wp;
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd; pstrb = st;
    lat = 0; got = 1'b0; err = 1'b0; rd = 32'h0; wp = 8'h0;
    while (!got && lat < 40) begin
      @(posedge pclk); #1;
      lat++;
      penable = 1'b1;
      if (pready) begin
        got = 1'b1; err = pslverr; rd = prdata; wp = wr_pulse;
      end
    end
    if (!got) lat = -1;
    chk({tag, " latency"}, 256'(lat), 256'(3));
    chk({tag, " pslverr"}, 256'(err), 256'(exp_err));
    chk({tag, " prdata"}, 256'(rd), 256'(exp_rd));
    chk({tag, " wr_pulse"}, 256'(wp), 256'(exp_wp));
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    chk({tag, " pready after"}, 256'(pready), 256'(0));
    chk({tag, " prdata after"}, 256'(prdata), 256'(0));
    chk({tag, " wr_pulse after"}, 256'(wr_pulse), 256'(0));
    chk({tag, " reg_q"}, reg_q, model_flat());
    $display("xfer %s addr=%08h wr=%0d wd=%08h strb=%h -> err=%0d rd=%08h wp=%02h lat=%0d",
             tag, addr, wr, wd, st, err, rd, wp, lat);
  endtask

  initial begin
    logic        e;
    logic [31:0] r;
    logic [7:0]  w;
    logic [31:0] a;
    logic [31:0] d;
    logic        wrr;
    logic [3:0]  s;
    int          l1, l0, l4;

    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0;
    model_reset();
    repeat (3) @(posedge pclk);
    #1; preset = 1'b0;
    chk("reset pready", 256'(pready), 256'(0));
    chk("reset pslverr", 256'(pslverr), 256'(0));
    chk("reset prdata", 256'(prdata), 256'(0));
    chk("reset wr_pulse", 256'(wr_pulse), 256'(0));
    chk("reset reg_q", reg_q, 256'(0));

    // Latency of the three wait-state builds on one shared read.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 32'h0; pwrite = 1'b0;
    l0 = -1; l1 = -1; l4 = -1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge pclk); #1;
      penable = 1'b1;
      if (pready0 && l0 < 0) l0 = n;
      if (pready  && l1 < 0) l1 = n;
      if (pready4 && l4 < 0) l4 = n;
    end
    psel = 1'b0; penable = 1'b0;
    chk("latency ws0", 256'(l0), 256'(2));
    chk("latency ws1", 256'(l1), 256'(3));
    chk("latency ws4", 256'(l4), 256'(6));
    $display("xfer latency ws0=%0d ws1=%0d ws4=%0d", l0, l1, l4);

    // Directed table.
    tbl[0]  = '{32'h04, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0,        8'h02};
    tbl[1]  = '{32'h08, 1'b1, 32'h11223344, 4'hF, 1'b0, 1'b0, 32'h0,        8'h04};
    tbl[2]  = '{32'h08, 1'b1, 32'hAABBCCDD, 4'h5, 1'b0, 1'b0, 32'h0,        8'h04};
    tbl[3]  = '{32'h08, 1'b0, 32'h0,        4'hF, 1'b0, 1'b0, 32'h11BB33DD, 8'h00};
    tbl[4]  = '{32'h20, 1'b0, 32'h0,        4'hF, 1'b0, 1'b1, 32'h0,        8'h00};
    tbl[5]  = '{32'h06, 1'b0, 32'h0,        4'hF, 1'b0, 1'b1, 32'h0,        8'h00};
    tbl[6]  = '{32'h1C, 1'b1, 32'h12345678, 4'hF, 1'b0, 1'b1, 32'h0,        8'h00};
    tbl[7]  = '{32'h1C, 1'b0, 32'h0,        4'hF, 1'b0, 1'b0, 32'h0,        8'h00};
    tbl[8]  = '{32'h0C, 1'b1, 32'h5,        4'hF, 1'b0, 1'b0, 32'h0,        8'h08};
    tbl[9]  = '{32'h0C, 1'b0, 32'h0,        4'h0, 1'b1, 1'b0, 32'h5,        8'h00};
    tbl[10] = '{32'h10, 1'b1, 32'h99999999, 4'h0, 1'b1, 1'b0, 32'h0,        8'h10};
    tbl[11] = '{32'h04, 1'b0, 32'h0,        4'hF, 1'b0, 1'b0, 32'hDEADBEEF, 8'h00};

    @(posedge pclk); #1;
    for (int i = 0; i < 12; i++) begin
      if (!tbl[i].b2b) begin
        @(posedge pclk); #1;
      end
      model_xfer(tbl[i].addr, tbl[i].wr, tbl[i].wd, tbl[i].st, e, r, w);
      xfer_check($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].wr, tbl[i].wd, tbl[i].st,
                 tbl[i].err, tbl[i].rd, tbl[i].wp);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 150; i++) begin
      a = 32'($urandom_range(0, 7)) * 4;
      case ($urandom_range(0, 9))
        0: a = a | 32'($urandom_range(1, 3));
        1: a = a | (32'h1 << $urandom_range(5, 31));
        default: ;
      endcase
      wrr = 1'($urandom_range(0, 1));
      d   = $urandom;
      s   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) begin
        @(posedge pclk); #1;
      end
      model_xfer(a, wrr, d, s, e, r, w);
      xfer_check($sformatf("rnd%0d", i), a, wrr, d, s, e, r, w);
    end

    // Abort: psel drops during ACCESS.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 32'h14; pwrite = 1'b1; pwdata = 32'hA5A5F00D; pstrb = 4'hF;
    @(posedge pclk); #1;
    psel = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(posedge pclk); #1;
      chk("abort pready", 256'(pready), 256'(0));
      chk("abort wr_pulse", 256'(wr_pulse), 256'(0));
    end
    chk("abort reg_q", reg_q, model_flat());
    $display("xfer abort addr=00000014");
    model_xfer(32'h14, 1'b0, 32'h0, 4'hF, e, r, w);
    xfer_check("after abort", 32'h14, 1'b0, 32'h0, 4'hF, e, r, w);

    // Reset while in ACCESS.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 32'h18; pwrite = 1'b1; pwdata = 32'h0BADF00D; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1; preset = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0; psel = 1'b0; penable = 1'b0;
    model_reset();
    chk("rst access pready", 256'(pready), 256'(0));
    chk("rst access pslverr", 256'(pslverr), 256'(0));
    chk("rst access prdata", 256'(prdata), 256'(0));
    chk("rst access wr_pulse", 256'(wr_pulse), 256'(0));
    chk("rst access reg_q", reg_q, 256'(0));
    for (int n = 0; n < 4; n++) begin
      @(posedge pclk); #1;
      chk("rst access no pready", 256'(pready), 256'(0));
    end
    $display("xfer reset-in-access addr=00000018");

    // Bank still works after the reset.
    model_xfer(32'h18, 1'b1, 32'h13572468, 4'hF, e, r, w);
    xfer_check("post rst wr", 32'h18, 1'b1, 32'h13572468, 4'hF, e, r, w);
    model_xfer(32'h18, 1'b0, 32'h0, 4'hF, e, r, w);
    xfer_check("post rst rd", 32'h18, 1'b0, 32'h0, 4'hF, e, r, w);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
